// File: rtl/zynet_run_ctrl.sv
// Run controller for one network inference frame.
// It accepts a frame from upstream and launches the serializer, then pulses
// start to the network. While the network runs it counts samples and cycles,
// and it hands the result downstream. It tracks timeout and sample-count
// errors in sticky flags. Only one frame is in flight at a time.
//
// Handshake rule: on every valid/ready (or valid/yumi) pair, a transfer
// happens on a rising edge where both are high. The valid side holds its
// data until that edge. Ready and yumi are combinational only where noted
// (IDLE pass-through, DONE yumi pass-through).
module zynet_run_ctrl #(
  parameter int NUM_SAMPLES    = 256,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 frame_valid_i,
  output logic                 frame_ready_o,
  output logic                 ser_valid_o,
  input  logic                 ser_ready_i,
  input  logic                 fifo_empty_i,
  input  logic                 net_ren_i,
  output logic                 net_start_o,
  input  logic                 net_valid_i,
  output logic                 net_yumi_o,
  output logic                 out_valid_o,
  input  logic                 out_yumi_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 sample_err_o,
  output logic [CNT_WIDTH-1:0] frame_count_o,
  output logic [2:0]           state_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam int SW = $clog2(NUM_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SAMPLES_FULL = SW'(NUM_SAMPLES);
  localparam logic [TW-1:0] CYCLE_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        sample_cnt_q, sample_cnt_d;
  logic [TW-1:0]        cycle_cnt_q, cycle_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 sample_err_q, sample_err_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic                 sample_rd;
  logic [SW-1:0]        sample_inc;

  // Sample count including a read in the current cycle, saturating at a full frame
  always_comb begin
    sample_rd  = net_ren_i && !fifo_empty_i;
    sample_inc = sample_cnt_q;
    if (sample_rd && (sample_cnt_q != SAMPLES_FULL)) begin
      sample_inc = sample_cnt_q + SW'(1);
    end
  end

  // Next-state logic: FSM transitions, counters and sticky flags.
  // A flag set in the same cycle as clear_i wins over the clear.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    timeout_d    = timeout_q;
    sample_err_d = sample_err_q;
    frame_cnt_d  = frame_cnt_q;

    if (clear_i) begin
      timeout_d    = 1'b0;
      sample_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (frame_valid_i && ser_ready_i) begin
          state_d = START;
        end
      end
      START: begin
        sample_cnt_d = '0;
        cycle_cnt_d  = '0;
        state_d      = RUN;
      end
      RUN: begin
        sample_cnt_d = sample_inc;
        cycle_cnt_d  = cycle_cnt_q + TW'(1);
        // A result arriving on the last allowed cycle still counts as done
        if (net_valid_i) begin
          state_d = DONE;
          if (sample_inc != SAMPLES_FULL) begin
            sample_err_d = 1'b1;
          end
        end else if (cycle_cnt_q == CYCLE_LAST) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (out_yumi_i) begin
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          state_d     = IDLE;
        end
      end
      ERR: begin
        if (clear_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      sample_err_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      timeout_q    <= timeout_d;
      sample_err_q <= sample_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    ser_valid_o   = (state_q == IDLE) && frame_valid_i;
    frame_ready_o = (state_q == IDLE) && ser_ready_i;
    net_start_o   = (state_q == START);
    out_valid_o   = (state_q == DONE);
    net_yumi_o    = (state_q == DONE) && out_yumi_i;
    busy_o        = (state_q != IDLE);
    timeout_o     = timeout_q;
    sample_err_o  = sample_err_q;
    frame_count_o = frame_cnt_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_zynet_run_ctrl.sv
// Directed-plus-random bench for zynet_run_ctrl with a small frame size so
// that timeout, short-frame and counter-wrap cases fit in a short run.
module tb_zynet_run_ctrl;

  localparam int N  = 32;
  localparam int TO = 64;
  localparam int CW = 2;

  logic          clk;
  logic          reset_n;
  logic          frame_valid, frame_ready;
  logic          ser_valid, ser_ready;
  logic          fifo_empty, net_ren;
  logic          net_start;
  logic          net_valid, net_yumi;
  logic          out_valid, out_yumi;
  logic          clear;
  logic          busy, timeout, sample_err;
  logic [CW-1:0] frame_count;
  logic [2:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: frames delivered, sticky flags
  int            exp_count = 0;
  bit            exp_serr  = 1'b0;
  bit            exp_to    = 1'b0;
  logic [CW-1:0] exp_q[$];

  zynet_run_ctrl #(
    .NUM_SAMPLES   (N),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .frame_valid_i (frame_valid),
    .frame_ready_o (frame_ready),
    .ser_valid_o   (ser_valid),
    .ser_ready_i   (ser_ready),
    .fifo_empty_i  (fifo_empty),
    .net_ren_i     (net_ren),
    .net_start_o   (net_start),
    .net_valid_i   (net_valid),
    .net_yumi_o    (net_yumi),
    .out_valid_o   (out_valid),
    .out_yumi_i    (out_yumi),
    .clear_i       (clear),
    .busy_o        (busy),
    .timeout_o     (timeout),
    .sample_err_o  (sample_err),
    .frame_count_o (frame_count),
    .state_o       (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold frame_valid under back-pressure, then complete the frame handshake
  // and step through the start pulse. Returns #1 after the first RUN negedge.
  task automatic start_frame(input int bp);
    frame_valid = 1'b1;
    ser_ready   = 1'b0;
    for (int i = 0; i < bp; i++) begin
      #1;
      check("bp_busy", busy, 0);
      check("bp_start", net_start, 0);
      check("bp_frame_ready", frame_ready, 0);
      check("bp_ser_valid", ser_valid, 1);
      @(negedge clk);
    end
    ser_ready = 1'b1;
    #1;
    check("hs_frame_ready", frame_ready, 1);
    check("hs_ser_valid", ser_valid, 1);
    exp_q.push_back(CW'((exp_count + 1) % (1 << CW)));
    @(negedge clk);
    frame_valid = 1'b0;
    ser_ready   = 1'b0;
    #1;
    check("start_pulse", net_start, 1);
    check("start_busy", busy, 1);
    check("start_ser_valid", ser_valid, 0);
    @(negedge clk);
    #1;
    check("start_one_cycle", net_start, 0);
  endtask

  // Full frame: `reads` effective samples over `valid_cycle` RUN cycles, with
  // the result arriving in RUN cycle `valid_cycle` (optionally with a read).
  task automatic run_frame(input int bp, input int reads, input int valid_cycle,
                           input bit read_on_valid, input bit clear_in_done);
    int need;
    int r;
    int hold;
    bit do_rd;
    start_frame(bp);
    need = reads - int'(read_on_valid);
    r    = 0;
    for (int i = 0; i < valid_cycle; i++) begin
      do_rd = ((need - r) >= (valid_cycle - i)) ||
              (((need - r) > 0) && ($urandom_range(0, 1) == 1));
      if (do_rd) begin
        net_ren    = 1'b1;
        fifo_empty = 1'b0;
        r++;
      end else if ($urandom_range(0, 1) == 1) begin
        net_ren    = 1'b1;
        fifo_empty = 1'b1;
      end else begin
        net_ren    = 1'b0;
        fifo_empty = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    net_valid  = 1'b1;
    net_ren    = read_on_valid;
    fifo_empty = 1'b0;
    #1;
    check("run_busy", busy, 1);
    check("run_no_out_valid", out_valid, 0);
    check("run_no_timeout", timeout, exp_to);
    if (((reads < N) ? reads : N) != N) exp_serr = 1'b1;
    @(negedge clk);
    net_valid   = 1'b0;
    net_ren     = 1'b0;
    frame_valid = 1'b1;
    ser_ready   = 1'b1;
    #1;
    check("done_out_valid", out_valid, 1);
    check("done_sample_err", sample_err, exp_serr);
    check("done_timeout", timeout, exp_to);
    check("done_frame_ready", frame_ready, 0);
    check("done_ser_valid", ser_valid, 0);
    check("done_net_yumi_idle", net_yumi, 0);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("done_hold", out_valid, 1);
    end
    if (clear_in_done) begin
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      exp_serr = 1'b0;
      exp_to   = 1'b0;
      #1;
      check("clear_done_flag", sample_err, 0);
      check("clear_keeps_done", out_valid, 1);
    end
    @(negedge clk);
    out_yumi = 1'b1;
    #1;
    check("yumi_pass", net_yumi, 1);
    @(negedge clk);
    out_yumi    = 1'b0;
    frame_valid = 1'b0;
    ser_ready   = 1'b0;
    exp_count   = (exp_count + 1) % (1 << CW);
    #1;
    check("end_busy", busy, 0);
    check("end_out_valid", out_valid, 0);
    check("frame_count", frame_count, exp_q.pop_front());
  endtask

  // Frame whose result never comes: expect ERR after TO RUN cycles, then clear
  task automatic timeout_frame();
    start_frame(0);
    void'(exp_q.pop_back());
    for (int i = 0; i < TO; i++) begin
      net_ren    = 1'($urandom_range(0, 1));
      fifo_empty = 1'($urandom_range(0, 1));
      if (i == TO - 1) begin
        #1;
        check("to_last_run_busy", busy, 1);
        check("to_last_run_flag", timeout, 0);
      end
      @(negedge clk);
    end
    net_ren     = 1'b0;
    fifo_empty  = 1'b0;
    frame_valid = 1'b1;
    ser_ready   = 1'b1;
    exp_to      = 1'b1;
    #1;
    check("err_timeout", timeout, 1);
    check("err_busy", busy, 1);
    check("err_frame_ready", frame_ready, 0);
    check("err_ser_valid", ser_valid, 0);
    check("err_out_valid", out_valid, 0);
    check("err_sample_err", sample_err, exp_serr);
    repeat (2) @(negedge clk);
    #1;
    check("err_stays", busy, 1);
    clear = 1'b1;
    #1;
    check("clear_is_sync", timeout, 1);
    @(negedge clk);
    clear       = 1'b0;
    frame_valid = 1'b0;
    ser_ready   = 1'b0;
    exp_to      = 1'b0;
    exp_serr    = 1'b0;
    #1;
    check("clear_timeout", timeout, 0);
    check("clear_to_idle", busy, 0);
  endtask

  // Abort a frame part-way through RUN with an asynchronous reset
  task automatic reset_mid_run(input int reads);
    start_frame(0);
    void'(exp_q.pop_back());
    for (int i = 0; i < reads; i++) begin
      net_ren    = 1'b1;
      fifo_empty = 1'b0;
      @(negedge clk);
    end
    net_ren = 1'b0;
    #2;
    reset_n     = 1'b0;
    frame_valid = 1'b1;
    ser_ready   = 1'b1;
    exp_count   = 0;
    exp_serr    = 1'b0;
    exp_to      = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_sample_err", sample_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_frame_ready_pass", frame_ready, 1);
    check("rst_ser_valid_pass", ser_valid, 1);
    @(negedge clk);
    frame_valid = 1'b0;
    ser_ready   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int rd;
    int vc;
    bit rov;
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    ser_ready   = 1'b0;
    fifo_empty  = 1'b0;
    net_ren     = 1'b0;
    net_valid   = 1'b0;
    out_yumi    = 1'b0;
    clear       = 1'b0;
    repeat (3) @(negedge clk);
    frame_valid = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_count", frame_count, 0);
    check("reset_timeout", timeout, 0);
    check("reset_sample_err", sample_err, 0);
    check("reset_net_start", net_start, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_net_yumi", net_yumi, 0);
    check("reset_ser_valid_pass", ser_valid, 1);
    check("reset_frame_ready_low", frame_ready, 0);
    ser_ready = 1'b1;
    #1;
    check("reset_frame_ready_pass", frame_ready, 1);

    // first frame accepted on the first edge after reset release
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(0, N, N + 2, 1'b0, 1'b0);

    // back-pressure then nominal
    run_frame(5, N, $urandom_range(N, TO - 2), 1'b0, 1'b0);

    // random full (and oversaturated) frames, sometimes with a read on the valid cycle
    for (int k = 0; k < 3; k++) begin
      rd  = ($urandom_range(0, 1) == 1) ? N : N + 3;
      rov = 1'($urandom_range(0, 1));
      vc  = $urandom_range(rd - int'(rov), TO - 2);
      run_frame(0, rd, vc, rov, 1'b0);
    end

    // last read lands in the net_valid cycle and completes the frame exactly
    run_frame(0, N, N + 4, 1'b1, 1'b0);

    // short frame sets the sticky flag; it survives a good frame; clear in DONE
    run_frame(0, N - 1, N + 1, 1'b0, 1'b0);
    run_frame(0, N, N + 3, 1'b0, 1'b0);
    run_frame(0, N, N, 1'b0, 1'b1);

    // short by one even with a read on the valid cycle, then clear in IDLE
    run_frame(0, N - 1, N + 5, 1'b1, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    exp_serr = 1'b0;
    #1;
    check("clear_idle_flag", sample_err, 0);
    check("clear_idle_state", busy, 0);

    timeout_frame();

    // result arrives on the very cycle the timeout would fire
    run_frame(0, N, TO - 1, 1'b0, 1'b0);
    check("simul_no_timeout", timeout, 0);

    // set the sticky error, then reset mid-run
    run_frame(0, N - 2, N + 2, 1'b0, 1'b0);
    reset_mid_run(N / 2);

    // five frames after reset wrap the 2-bit counter to 1
    for (int k = 0; k < 5; k++) begin
      run_frame(0, N, $urandom_range(N, TO - 2), 1'b0, 1'b0);
    end
    check("wrap_5_frames", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
